// File: rtl/vga_pkg.sv
// Shared VGA definitions for the timing generator, rectangle renderer and box mover.
//   - 640x480 active-area timing constants (horizontal and vertical porches/pulse widths)
//   - Box-mover FSM state encoding
//   - Per-axis direction encoding
package vga_pkg;

    localparam int unsigned WIDTH  = 640;
    localparam int unsigned HEIGHT = 480;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_PW   = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_PW   = 2;
    localparam int unsigned V_BP   = 33;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } moverStateT;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/vga_axis_bounce.sv
// Single-axis step/reflect unit for the box mover (purely combinational).
// Moves a position by STEP in the current direction, clamping against the
// walls at 0 and LIMIT-SIZE and reversing direction on contact.
//   iPos        current left/top edge
//   iDir        current direction (DIR_POS / DIR_NEG)
//   oNextPos    position after this step
//   oNextDir    direction after this step
//   oReflected  1 when this step hit a wall and reversed direction
module vga_axis_bounce #(
    parameter int unsigned LIMIT = 640,
    parameter int unsigned SIZE  = 60,
    parameter int unsigned STEP  = 2
) (
    input  logic [9:0] iPos,
    input  logic       iDir,
    output logic [9:0] oNextPos,
    output logic       oNextDir,
    output logic       oReflected
);
    import vga_pkg::*;

    // 11-bit arithmetic so pos+SIZE+STEP cannot wrap for any legal 10-bit position.
    localparam logic [10:0] LIMIT11 = 11'(LIMIT);
    localparam logic [10:0] SPAN11  = 11'(SIZE + STEP);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [9:0]  MAX_POS = 10'(LIMIT - SIZE);

    logic [10:0] pos11;

    always_comb begin
        pos11      = {1'b0, iPos};
        oNextPos   = iPos;
        oNextDir   = iDir;
        oReflected = 1'b0;
        if (iDir == DIR_POS) begin
            if (pos11 + SPAN11 > LIMIT11) begin
                oNextPos   = MAX_POS;
                oNextDir   = DIR_NEG;
                oReflected = 1'b1;
            end else begin
                oNextPos = 10'(pos11 + STEP11);
            end
        end else begin
            if (pos11 < STEP11) begin
                oNextPos   = '0;
                oNextDir   = DIR_POS;
                oReflected = 1'b1;
            end else begin
                oNextPos = 10'(pos11 - STEP11);
            end
        end
    end

endmodule

// File: rtl/vga_box_mover.sv
// Box mover: produces the bouncing square's top-left corner and size for the
// rectangle renderer. Steps once every FRAME_DIV frames, using the falling
// edge of vertical sync as the frame reference, so every update lands in
// vertical blanking and X/Y always change together.
//   iClk        pixel clock
//   iRst        synchronous reset, active-low
//   iVS         vertical sync, active-low pulse
//   iEnable     1 = motion enabled, 0 = position frozen (frame ticks continue)
//   oShapeX     square left edge
//   oShapeY     square top edge
//   oShapeSize  square edge length (constant SIZE)
//   oFrameTick  one-cycle pulse on the cycle the outputs are committed
//   oColor      12-bit RGB, only when VGA_BOX_MOVER_COLOR_CYCLE_EN is defined;
//               advances by 12'h135 on each commit where either axis bounced
module vga_box_mover #(
    parameter int unsigned WIDTH     = vga_pkg::WIDTH,
    parameter int unsigned HEIGHT    = vga_pkg::HEIGHT,
    parameter int unsigned SIZE      = 60,
    parameter int unsigned X_INIT    = 290,
    parameter int unsigned Y_INIT    = 210,
    parameter int unsigned STEP      = 2,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iVS,
    input  logic        iEnable,
    output logic [9:0]  oShapeX,
    output logic [9:0]  oShapeY,
    output logic [9:0]  oShapeSize,
    output logic        oFrameTick
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
    ,
    output logic [11:0] oColor
`endif
);
    import vga_pkg::*;

    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    if (SIZE >= WIDTH || SIZE >= HEIGHT || WIDTH > 1023 || HEIGHT > 1023 ||
        X_INIT > WIDTH - SIZE || Y_INIT > HEIGHT - SIZE ||
        STEP < 1 || STEP > 1023 || FRAME_DIV < 1) begin : gCfgError
        $error("vga_box_mover: illegal parameter combination");
    end

    moverStateT state, stateNext;
    logic             vsD;
    logic             frameEdge;
    logic [CNT_W-1:0] frameCnt;
    logic             dirX, dirY;
    logic [9:0]       shX, shY;
    logic             shDirX, shDirY;
    logic [9:0]       nextX, nextY;
    logic             nDirX, nDirY;
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
    logic             reflX, reflY;
    logic             shRefl;
`endif

    // Start of the sync pulse; vsD resets low so a low iVS out of reset is not an edge.
    assign frameEdge  = vsD & ~iVS;
    assign oShapeSize = 10'(SIZE);

    vga_axis_bounce #(
        .LIMIT (WIDTH),
        .SIZE  (SIZE),
        .STEP  (STEP)
    ) uBounceX (
        .iPos       (oShapeX),
        .iDir       (dirX),
        .oNextPos   (nextX),
        .oNextDir   (nDirX),
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        .oReflected (reflX)
`else
        .oReflected ()
`endif
    );

    vga_axis_bounce #(
        .LIMIT (HEIGHT),
        .SIZE  (SIZE),
        .STEP  (STEP)
    ) uBounceY (
        .iPos       (oShapeY),
        .iDir       (dirY),
        .oNextPos   (nextY),
        .oNextDir   (nDirY),
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        .oReflected (reflY)
`else
        .oReflected ()
`endif
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            S_WAIT: begin
                if (frameEdge) begin
                    stateNext = (iEnable && frameCnt == CNT_LAST) ? S_CALC : S_COMMIT;
                end
            end
            S_CALC:   stateNext = S_COMMIT;
            S_COMMIT: stateNext = S_WAIT;
            default:  stateNext = S_WAIT;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state      <= S_WAIT;
            vsD        <= 1'b0;
            frameCnt   <= '0;
            dirX       <= DIR_POS;
            dirY       <= DIR_POS;
            shX        <= 10'(X_INIT);
            shY        <= 10'(Y_INIT);
            shDirX     <= DIR_POS;
            shDirY     <= DIR_POS;
            oShapeX    <= 10'(X_INIT);
            oShapeY    <= 10'(Y_INIT);
            oFrameTick <= 1'b0;
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
            shRefl     <= 1'b0;
            oColor     <= 12'hFFF;
`endif
        end else begin
            state      <= stateNext;
            vsD        <= iVS;
            oFrameTick <= 1'b0;
            unique case (state)
                S_WAIT: begin
                    if (frameEdge) begin
                        // Preload the shadow with the current state so a
                        // non-stepping frame commits an unchanged position.
                        shX    <= oShapeX;
                        shY    <= oShapeY;
                        shDirX <= dirX;
                        shDirY <= dirY;
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
                        shRefl <= 1'b0;
`endif
                        if (iEnable) begin
                            frameCnt <= (frameCnt == CNT_LAST) ? '0 : frameCnt + CNT_W'(1);
                        end
                    end
                end
                S_CALC: begin
                    shX    <= nextX;
                    shY    <= nextY;
                    shDirX <= nDirX;
                    shDirY <= nDirY;
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
                    shRefl <= reflX | reflY;
`endif
                end
                S_COMMIT: begin
                    oShapeX    <= shX;
                    oShapeY    <= shY;
                    dirX       <= shDirX;
                    dirY       <= shDirY;
                    oFrameTick <= 1'b1;
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
                    if (shRefl) begin
                        oColor <= oColor + 12'h135;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_box_mover.sv
// Directed bench for vga_box_mover: four instances with different parameter
// sets share clock, reset and vsync; each has its own enable.
module tb_vga_box_mover;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst, vs;
    logic enA, enB, enC, enD;

    logic [9:0] xA, yA, sA, xB, yB, sB, xC, yC, sC, xD, yD, sD;
    logic       tickA, tickB, tickC, tickD;
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
    logic [11:0] colA, colB, colC, colD;
`endif

    int nTests = 0;
    int nFail  = 0;
    int ticksA = 0;
    int ticksD = 0;
    int snap;

    always @(posedge clk) begin
        if (tickA) ticksA <= ticksA + 1;
        if (tickD) ticksD <= ticksD + 1;
    end

    // A: defaults
    vga_box_mover uDutA (
        .iClk (clk), .iRst (rst), .iVS (vs), .iEnable (enA),
        .oShapeX (xA), .oShapeY (yA), .oShapeSize (sA), .oFrameTick (tickA)
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        , .oColor (colA)
`endif
    );

    // B: starts next to the bottom-right corner
    vga_box_mover #(.X_INIT (579), .Y_INIT (419)) uDutB (
        .iClk (clk), .iRst (rst), .iVS (vs), .iEnable (enB),
        .oShapeX (xB), .oShapeY (yB), .oShapeSize (sB), .oFrameTick (tickB)
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        , .oColor (colB)
`endif
    );

    // C: narrow field, X bounces between both walls quickly
    vga_box_mover #(.WIDTH (64), .SIZE (60), .X_INIT (1)) uDutC (
        .iClk (clk), .iRst (rst), .iVS (vs), .iEnable (enC),
        .oShapeX (xC), .oShapeY (yC), .oShapeSize (sC), .oFrameTick (tickC)
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        , .oColor (colC)
`endif
    );

    // D: one step every three frames
    vga_box_mover #(.FRAME_DIV (3)) uDutD (
        .iClk (clk), .iRst (rst), .iVS (vs), .iEnable (enD),
        .oShapeX (xD), .oShapeY (yD), .oShapeSize (sD), .oFrameTick (tickD)
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        , .oColor (colD)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Short vsync pulse: low for two edges, then high long enough for the commit.
    task automatic vsPulse();
        @(posedge clk);
        #1 vs = 1'b0;
        repeat (2) @(posedge clk);
        #1 vs = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    int expC [6] = '{3, 4, 2, 0, 0, 2};

    initial begin
        rst = 1'b0;
        vs  = 1'b1;
        enA = 1'b0; enB = 1'b0; enC = 1'b0; enD = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 1: reset state, then idle with vsync high
        checkVal("rstX", 32'(xA), 290);
        checkVal("rstY", 32'(yA), 210);
        checkVal("rstSize", 32'(sA), 60);
        checkVal("rstTick", 32'(tickA), 0);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkVal("idleX", 32'(xA), 290);
        checkVal("idleY", 32'(yA), 210);
        checkVal("idleTicks", 32'(ticksA), 0);

        // 2: one step, latency and atomic X/Y update
        enA = 1'b1;
        @(posedge clk);
        #1 vs = 1'b0;
        @(posedge clk);
        #1 checkVal("lat1X", 32'(xA), 290);
        @(posedge clk);
        #1;
        checkVal("lat2X", 32'(xA), 290);
        checkVal("lat2Y", 32'(yA), 210);
        checkVal("lat2Tick", 32'(tickA), 0);
        @(posedge clk);
        #1;
        checkVal("lat3X", 32'(xA), 292);
        checkVal("lat3Y", 32'(yA), 212);
        checkVal("lat3Tick", 32'(tickA), 1);
        vs = 1'b1;
        @(posedge clk);
        #1 checkVal("tickWidth", 32'(tickA), 0);
        repeat (6) @(posedge clk);
        #1 checkVal("oneTick", 32'(ticksA), 1);
        enA = 1'b0;

        // 3: corner hit, both axes reverse together
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        checkVal("colRst", 32'(colB), 32'h0FFF);
`endif
        enB = 1'b1;
        vsPulse();
        checkVal("cornerX1", 32'(xB), 580);
        checkVal("cornerY1", 32'(yB), 420);
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        checkVal("col1", 32'(colB), 32'h0134);
`endif
        vsPulse();
        checkVal("cornerX2", 32'(xB), 578);
        checkVal("cornerY2", 32'(yB), 418);
`ifdef VGA_BOX_MOVER_COLOR_CYCLE_EN
        checkVal("col2", 32'(colB), 32'h0134);
`endif
        enB = 1'b0;

        // 4: narrow field: right wall, run left, left-wall clamp, back right
        enC = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vsPulse();
            checkVal($sformatf("narrowX%0d", i + 1), 32'(xC), 32'(expC[i]));
        end
        checkVal("narrowY", 32'(yC), 222);
        enC = 1'b0;

        // 5: frame divider and enable freeze
        snap = ticksD;
        enD  = 1'b1;
        vsPulse(); checkVal("divX1", 32'(xD), 290);
        vsPulse(); checkVal("divX2", 32'(xD), 290);
        vsPulse(); checkVal("divX3", 32'(xD), 292);
        checkVal("divY3", 32'(yD), 212);
        vsPulse(); checkVal("divX4", 32'(xD), 292);
        vsPulse(); checkVal("divX5", 32'(xD), 292);
        vsPulse(); checkVal("divX6", 32'(xD), 294);
        checkVal("divTicks6", 32'(ticksD - snap), 6);
        enD = 1'b0;
        vsPulse();
        vsPulse();
        checkVal("frozenX", 32'(xD), 294);
        checkVal("frozenY", 32'(yD), 214);
        checkVal("frozenTicks", 32'(ticksD - snap), 8);
        enD = 1'b1;
        vsPulse();
        vsPulse();
        checkVal("heldCntX", 32'(xD), 294);
        vsPulse();
        checkVal("heldCntStep", 32'(xD), 296);
        enD = 1'b0;

        // 6: reset during CALC, then vsync low across reset release
        enA  = 1'b1;
        snap = ticksA;
        @(posedge clk);
        #1 vs = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checkVal("midRstX", 32'(xA), 290);
        checkVal("midRstY", 32'(yA), 210);
        checkVal("midRstTick", 32'(tickA), 0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkVal("vsLowX", 32'(xA), 290);
        checkVal("vsLowTicks", 32'(ticksA - snap), 0);
        vs = 1'b1;
        repeat (3) @(posedge clk);
        vsPulse();
        checkVal("postRstX", 32'(xA), 292);
        checkVal("postRstY", 32'(yA), 212);
        checkVal("postRstTicks", 32'(ticksA - snap), 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/vga_box_mover.md
Name: vga_box_mover

Overview:
- Upstream stage of the rectangle renderer: generates the square's top-left position and size (ShapeX/ShapeY/ShapeSize) consumed by the rectangle drawing stage.
- Advances the square once per N frames, using the vertical-sync output of the VGA timing generator as the frame reference.
- Bounces off the active-area edges, reversing direction per axis.
- All position changes occur during vertical blanking, so the renderer never sees a torn frame.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- SIZE, 60, square edge length in pixels (SIZE < WIDTH, SIZE < HEIGHT)
- X_INIT, 290, reset X position (≤ WIDTH-SIZE)
- Y_INIT, 210, reset Y position (≤ HEIGHT-SIZE)
- STEP, 2, pixels moved per step per axis (≥1)
- FRAME_DIV, 1, frames per step (≥1)

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  synchronous reset, active-low
- iVS  in  1  vertical sync from timing generator, active-low pulse
- iEnable  in  1  1 = motion enabled; 0 = position frozen
- oShapeX  out  10  square left edge, pixel column
- oShapeY  out  10  square top edge, line
- oShapeSize  out  10  square size, constant = SIZE
- oFrameTick  out  1  one-cycle pulse when outputs are committed

Behaviour:
- Reset:
  - Triggered when iRst==0 at a posedge iClk.
  - oShapeX=X_INIT, oShapeY=Y_INIT, oShapeSize=SIZE, oFrameTick=0.
  - dirX=+, dirY=+, frame counter=0, vs_d=0, FSM=WAIT.
  - Reset mid-operation abandons any pending update.
- Frame edge: vs_d registers iVS each cycle; an edge is vs_d==1 && iVS==0, i.e. the start of the sync pulse.
  - vs_d resets to 0, so iVS already low out of reset is not treated as an edge.
- FSM:
  - WAIT: on an edge:
    - iEnable==0: go to COMMIT with positions unchanged.
    - iEnable==1 and counter < FRAME_DIV-1: increment the counter and go to COMMIT with positions unchanged.
    - iEnable==1 and counter == FRAME_DIV-1: clear the counter and go to CALC.
    - iEnable==0 holds the counter.
  - CALC: compute next X/Y and directions into shadow registers → COMMIT.
  - COMMIT: load oShapeX/oShapeY from shadow (or hold), assert oFrameTick for this cycle only → WAIT.
- Latency: outputs and oFrameTick change 3 clocks after the first cycle iVS is sampled low. X and Y update on the same edge and are never split.
- Edges arriving in CALC or COMMIT are ignored. They cannot occur with legal timing.
- X arithmetic, 11-bit unsigned to avoid overflow:
  - dirX=+: if X+SIZE+STEP > WIDTH, then X=WIDTH-SIZE and dirX=−; else X=X+STEP.
  - dirX=−: if X < STEP, then X=0 and dirX=+; else X=X−STEP.
- Y arithmetic: identical to X, using HEIGHT and dirY.
- Corner hit: both axes reverse independently in the same step.
- Square always satisfies 0 ≤ X ≤ WIDTH-SIZE and 0 ≤ Y ≤ HEIGHT-SIZE. Out-of-range parameters are a configuration error; add a simulation-only check at elaboration.

Optional Feature:
- Macro: VGA_BOX_MOVER_COLOR_CYCLE_EN
- Defined:
  - Adds output oColor[11:0] (4:4:4 RGB), reset value 12'hFFF.
  - Each COMMIT in which either axis reversed direction: oColor ← oColor + 12'h135, wrapping modulo 4096.
  - Updates on the same edge as the positions.
- Undefined: port and logic absent; renderer uses its fixed colour.

Decomposition:
- Shared package vga_pkg holds:
  - VGA timing localparams (WIDTH, HEIGHT, H_FP/H_PW/H_BP, V_FP/V_PW/V_BP) used by the timing generator, renderer and mover.
  - FSM state encoding typedef: WAIT, CALC, COMMIT.
  - Direction constants DIR_POS/DIR_NEG.
- One natural sub-module, vga_axis_bounce:
  - Per-axis step/reflect unit, parameterised by LIMIT, SIZE and STEP.
  - Inputs: position, dir. Outputs: next position, next dir, reflected flag.
  - Instantiated twice, for X/WIDTH and Y/HEIGHT.

Test Plan:
1. Default parameters, iRst=0 then 1, iVS held high → oShapeX=290, oShapeY=210, oShapeSize=60, oFrameTick=0; no change for 2 frames' worth of clocks.
2. iEnable=1, one VS pulse (800×525 frame, 40 ns clock) → exactly one oFrameTick; 3 clocks after iVS falls, X=292 and Y=212, both changing on the same edge.
3. X_INIT=579, Y_INIT=419, STEP=2 → step 1: X=580, Y=420 (corner, both reverse). Step 2: X=578, Y=418. With COLOR_CYCLE_EN: oColor 12'hFFF→12'h134 on step 1, then unchanged on step 2.
4. X_INIT=1, force dirX=− via a run ending on the left wall (X_INIT=1 with STEP=2 after reflection from a narrow WIDTH=64, SIZE=60) → X clamps to 0, dirX=+, next step X=2.
5. FRAME_DIV=3, 6 VS pulses → 6 oFrameTick pulses; position advances only on the 3rd and 6th. iEnable=0 for pulses 7–8 → ticks continue, X/Y frozen, counter held.
6. iRst asserted low during CALC after a qualifying edge → next cycle outputs = X_INIT/Y_INIT, no oFrameTick. iVS held low across reset release → no update until iVS goes high then low.
